// File: rtl/unity_ecc_symbol_encoder.sv
// Streaming encoder for the Unity ECC symbol code: forwards K data symbols
// and then appends an unweighted and a position-weighted check symbol.
module unity_ecc_symbol_encoder #(
  parameter int K = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_check,
  output logic       m_last
);

  localparam int IW = $clog2(K + 1);

  typedef enum logic [1:0] {
    DATA,
    CHK0,
    CHK1
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0]    acc0, acc0_nx;
  logic [7:0]    acc1, acc1_nx;
  logic          m_valid_nx, m_check_nx, m_last_nx;
  logic [7:0]    m_data_nx;
  logic          slot_free;
  logic [7:0]    weight;
  logic [7:0]    prod;

  // The output register can take a new symbol when empty or draining this cycle.
  assign slot_free = !m_valid || m_ready;
  assign weight    = 8'(idx) + 8'd1;
  // Only the low byte of the weighted product ever reaches the mod-256 sum.
  assign prod      = weight * s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DATA;
      idx     <= '0;
      acc0    <= 8'h00;
      acc1    <= 8'h00;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_check <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      acc0    <= acc0_nx;
      acc1    <= acc1_nx;
      m_valid <= m_valid_nx;
      m_data  <= m_data_nx;
      m_check <= m_check_nx;
      m_last  <= m_last_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    acc0_nx    = acc0;
    acc1_nx    = acc1;
    m_valid_nx = m_valid;
    m_data_nx  = m_data;
    m_check_nx = m_check;
    m_last_nx  = m_last;
    s_ready    = 1'b0;

    case (state)
      DATA: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          m_data_nx  = s_data;
          m_valid_nx = 1'b1;
          m_check_nx = 1'b0;
          m_last_nx  = 1'b0;
          idx_nx     = idx + IW'(1);
          acc0_nx    = acc0 + s_data;
          acc1_nx    = acc1 + prod;
          if (idx == IW'(K - 1)) state_nx = CHK0;
        end else if (slot_free) begin
          m_valid_nx = 1'b0;
        end
      end
      CHK0: begin
        if (slot_free) begin
          m_data_nx  = acc0;
          m_valid_nx = 1'b1;
          m_check_nx = 1'b1;
          m_last_nx  = 1'b0;
          state_nx   = CHK1;
        end
      end
      CHK1: begin
        // Clearing here lets the next codeword start from zero while check1 drains.
        if (slot_free) begin
          m_data_nx  = acc1;
          m_valid_nx = 1'b1;
          m_check_nx = 1'b1;
          m_last_nx  = 1'b1;
          acc0_nx    = 8'h00;
          acc1_nx    = 8'h00;
          idx_nx     = '0;
          state_nx   = DATA;
        end
      end
      default: state_nx = DATA;
    endcase
  end

endmodule

// File: tb/tb_unity_ecc_symbol_encoder.sv
// Scoreboard bench for unity_ecc_symbol_encoder: a K=8 instance for the main
// scenarios and a K=1 instance for the single-symbol codeword.
module tb_unity_ecc_symbol_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_valid, s_ready, m_valid, m_ready, m_check, m_last;
  logic [7:0] s_data, m_data;
  logic       k1_s_valid, k1_s_ready, k1_m_valid, k1_m_ready, k1_m_check, k1_m_last;
  logic [7:0] k1_s_data, k1_m_data;

  unity_ecc_symbol_encoder #(.K(8)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_check(m_check), .m_last(m_last)
  );

  unity_ecc_symbol_encoder #(.K(1)) dut_k1 (
    .clk(clk), .rst(rst),
    .s_valid(k1_s_valid), .s_ready(k1_s_ready), .s_data(k1_s_data),
    .m_valid(k1_m_valid), .m_ready(k1_m_ready), .m_data(k1_m_data),
    .m_check(k1_m_check), .m_last(k1_m_last)
  );

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int tp_start   = -1;
  logic bp_mode  = 1'b0;
  logic tp_mode  = 1'b0;
  logic b2b_mode = 1'b0;

  // Expected entries are {m_check, m_last, m_data}.
  logic [9:0] exp_q[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_v, exp_v1;
  logic       prev_stall;
  logic [9:0] prev_fields;

  logic [7:0] cw_basic [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
  logic [7:0] cw_ff    [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] cw_zero  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream readiness: always 1, or a random stall pattern during backpressure.
  initial begin
    m_ready    = 1'b1;
    k1_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_mode ? 1'(($urandom % 3) != 1) : 1'b1;
    end
  end

  // Monitor for the K=8 instance.
  always @(negedge clk) begin
    cycle++;
    if (prev_stall) begin
      checkOutput("stall_valid", 32'(m_valid), 32'd1);
      checkOutput("stall_fields", 32'({m_check, m_last, m_data}), 32'(prev_fields));
    end
    if (m_valid && !m_ready) checkOutput("stall_s_ready", 32'(s_ready), 32'd0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got 0x%0h expected none", {m_check, m_last, m_data});
      end else begin
        exp_v = exp_q.pop_front();
        checkOutput("out_symbol", 32'({m_check, m_last, m_data}), 32'(exp_v));
      end
      if (tp_mode && !m_check && tp_start < 0) tp_start = cycle;
      if (tp_mode && m_last) checkOutput("codeword_cycles", 32'(cycle - tp_start + 1), 32'd10);
      if (b2b_mode && m_last && s_valid) checkOutput("b2b_accept", 32'(s_ready), 32'd1);
    end
    prev_stall  <= m_valid && !m_ready;
    prev_fields <= {m_check, m_last, m_data};
  end

  // Monitor for the K=1 instance.
  always @(negedge clk) begin
    if (k1_m_valid && k1_m_ready) begin
      if (exp_q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL k1_unexpected_output: got 0x%0h expected none",
                 {k1_m_check, k1_m_last, k1_m_data});
      end else begin
        exp_v1 = exp_q1.pop_front();
        checkOutput("k1_out_symbol", 32'({k1_m_check, k1_m_last, k1_m_data}), 32'(exp_v1));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d);
    int waited;
    waited = 0;
    exp_q.push_back({2'b00, d});
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL accept_timeout: got no s_ready expected s_ready within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendCodeword(input logic [7:0] d [8], input logic [7:0] c0,
                              input logic [7:0] c1, input logic keep_valid);
    for (int i = 0; i < 8; i++) applyStimulus(d[i]);
    exp_q.push_back({2'b10, c0});
    exp_q.push_back({2'b11, c1});
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_q1.size() != 0); i++) @(negedge clk);
    if (exp_q.size() != 0 || exp_q1.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + exp_q1.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, "_m_data"},  32'(m_data),  32'h00);
    checkOutput({tag, "_m_check"}, 32'(m_check), 32'd0);
    checkOutput({tag, "_m_last"},  32'(m_last),  32'd0);
    checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    k1_s_valid = 1'b0;
    k1_s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;

    // Basic codeword with full throughput.
    tp_mode = 1'b1;
    sendCodeword(cw_basic, 8'h24, 8'hCC, 1'b0);
    waitDrain();
    tp_mode = 1'b0;

    // Wrap-around arithmetic.
    sendCodeword(cw_ff, 8'hF8, 8'hDC, 1'b0);
    waitDrain();

    // Backpressure.
    bp_mode = 1'b1;
    sendCodeword(cw_basic, 8'h24, 8'hCC, 1'b0);
    waitDrain();
    bp_mode = 1'b0;
    waitDrain();

    // Back-to-back codewords with s_valid held high.
    b2b_mode = 1'b1;
    sendCodeword(cw_basic, 8'h24, 8'hCC, 1'b1);
    sendCodeword(cw_zero, 8'h00, 8'h00, 1'b0);
    waitDrain();
    b2b_mode = 1'b0;

    // Reset after three accepted symbols discards the partial codeword.
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("midreset");
    checkOutput("midreset_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    sendCodeword(cw_basic, 8'h24, 8'hCC, 1'b0);
    waitDrain();

    // K=1 codeword.
    exp_q1.push_back({2'b00, 8'h5A});
    exp_q1.push_back({2'b10, 8'h5A});
    exp_q1.push_back({2'b11, 8'h5A});
    k1_s_valid = 1'b1;
    k1_s_data  = 8'h5A;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k1_s_ready) break;
    end
    @(posedge clk);
    #1;
    k1_s_valid = 1'b0;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
